// File: rtl/uart_tx_mmio_if.sv
// Data-port bus shared with data_ram: select, write strobe, byte enables,
// address and write data from the CPU, combinational read data back.
interface uart_tx_mmio_if;
   logic        en;
   logic        write_en;
   logic [3:0]  write_sel;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (output en, write_en, write_sel, addr, write_data, input read_data);
   modport slave  (input en, write_en, write_sel, addr, write_data, output read_data);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, programmable baud divisor,
// polling status and a level interrupt when the line drains.
module uart_tx_mmio #(
   parameter int FIFO_DEPTH  = 16,
   parameter int DEFAULT_DIV = 433
) (
   input  logic            i_clk,
   input  logic            i_rst,
   uart_tx_mmio_if.slave   bus,
   output logic            o_txd,
   output logic            o_irq
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          r_state;
   logic [15:0]     r_cnt;
   logic [15:0]     r_bit_div;
   logic [7:0]      r_shift;
   logic [2:0]      r_bit_idx;
   logic            r_txd;
   logic [15:0]     r_div;
   logic            r_tx_en;
   logic            r_ie;
   logic            r_overrun;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [AW:0]     r_count;

   logic            w_wr;
   logic [1:0]      w_reg;
   logic            w_empty;
   logic            w_full;
   logic            w_busy;
   logic            w_bit_end;
   logic            w_pop;
   logic            w_push_req;
   logic            w_push;
   logic [7:0]      w_head;
   logic [4:0]      w_cnt5;
   logic            w_unused;

   assign w_wr       = bus.en & bus.write_en;
   assign w_reg      = bus.addr[3:2];
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_busy     = (r_state != S_IDLE);
   assign w_bit_end  = (r_cnt == r_bit_div);
   // Pop from IDLE, or at the last cycle of STOP so frames run back to back.
   assign w_pop      = r_tx_en & ~w_empty &
                       ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
   assign w_push_req = w_wr & (w_reg == 2'd0) & bus.write_sel[0];
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_head     = r_mem[r_rptr];
   assign w_cnt5     = 5'(r_count);
   assign w_unused   = &{1'b0, bus.addr[31:4], bus.addr[1:0],
                         bus.write_data[31:16], bus.write_sel[3:2]};

   assign o_txd = r_txd;
   assign o_irq = r_ie & w_empty & ~w_busy;

   always_comb begin
      bus.read_data = '0;
      if (bus.en & ~bus.write_en) begin
         case (w_reg)
            2'd1:    bus.read_data = {23'b0, w_cnt5, r_overrun, w_empty, w_full, w_busy};
            2'd2:    bus.read_data = {16'b0, r_div};
            2'd3:    bus.read_data = {30'b0, r_ie, r_tx_en};
            default: bus.read_data = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_div     <= 16'(DEFAULT_DIV);
         r_tx_en   <= 1'b0;
         r_ie      <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr && w_reg == 2'd2) begin
            if (bus.write_sel[0]) r_div[7:0]  <= bus.write_data[7:0];
            if (bus.write_sel[1]) r_div[15:8] <= bus.write_data[15:8];
         end
         if (w_wr && w_reg == 2'd3 && bus.write_sel[0]) begin
            r_tx_en <= bus.write_data[0];
            r_ie    <= bus.write_data[1];
         end
         if (w_push_req && w_full && !w_pop)
            r_overrun <= 1'b1;
         else if (w_wr && w_reg == 2'd1 && bus.write_sel[0] && bus.write_data[3])
            r_overrun <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= bus.write_data[7:0];
   end

   // bit_div is latched at pop so DIV writes never disturb a frame in flight.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_div <= '0;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_txd     <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state   <= S_START;
                  r_cnt     <= '0;
                  r_bit_div <= r_div;
                  r_shift   <= w_head;
                  r_txd     <= 1'b0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_txd     <= r_shift[0];
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                     r_txd   <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_shift   <= r_shift >> 1;
                     r_txd     <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (w_pop) begin
                     r_state   <= S_START;
                     r_bit_div <= r_div;
                     r_shift   <= w_head;
                     r_txd     <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                     r_txd   <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: records txd/irq every cycle and compares against
// waveforms built from 8N1 framing rules for the bytes and divisors written.
module tb_uart_tx_mmio;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic txd, irq;
   int   checks = 0;
   int   failures = 0;

   uart_tx_mmio_if bus();

   uart_tx_mmio #(.FIFO_DEPTH(16), .DEFAULT_DIV(433)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus), .o_txd(txd), .o_irq(irq));

   always #5 clk = ~clk;

   bit rec = 1'b0;
   int wave_q[$];
   int irq_q[$];
   int exp_q[$];

   always @(negedge clk) if (rec) begin
      wave_q.push_back(int'(txd));
      irq_q.push_back(int'(irq));
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      bus.en = 1'b1; bus.write_en = 1'b1; bus.addr = {28'b0, r, 2'b00};
      bus.write_data = d; bus.write_sel = s;
      @(posedge clk);
      #1;
      bus.en = 1'b0; bus.write_en = 1'b0; bus.write_sel = 4'b0;
   endtask

   task automatic rd(input logic [1:0] r, output logic [31:0] d);
      @(negedge clk);
      bus.en = 1'b1; bus.write_en = 1'b0; bus.addr = {28'b0, r, 2'b00};
      #1;
      d = bus.read_data;
      bus.en = 1'b0;
   endtask

   task automatic rec_start();
      wave_q.delete(); irq_q.delete(); exp_q.delete();
      rec = 1'b1;
   endtask

   // Reference framing: start 0, data LSB first, stop 1, each cell div+1 cycles.
   function automatic void exp_frame(input logic [7:0] b, input int div);
      for (int k = 0; k < 10; k++) begin
         int lvl;
         lvl = (k == 0) ? 0 : (k == 9) ? 1 : int'(b[k-1]);
         for (int c = 0; c <= div; c++) exp_q.push_back(lvl);
      end
   endfunction

   function automatic int find_start();
      foreach (wave_q[i]) if (wave_q[i] == 0) return i;
      return -1;
   endfunction

   function automatic int first_diff(input int start);
      foreach (exp_q[i])
         if (start + i >= wave_q.size() || wave_q[start+i] != exp_q[i]) return i;
      return -1;
   endfunction

   task automatic test_reset();
      logic [31:0] d;
      #2 rst = 1'b0;
      #3;
      checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b want=1", txd); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
      cycles(2);
      @(negedge clk) rst = 1'b1;
      rd(2'd1, d); checks++; if (d !== 32'h004) begin failures++; $display("FAIL reset_status got=%h want=004", d); end
      rd(2'd2, d); checks++; if (d !== 32'd433) begin failures++; $display("FAIL reset_div got=%0d want=433", d); end
      rd(2'd3, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h want=0", d); end
      rd(2'd0, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL txdata_read got=%h want=0", d); end
   endtask

   task automatic test_single_byte();
      logic [31:0] d;
      int diff;
      wr(2'd2, 32'd3, 4'b0011);
      wr(2'd3, 32'd1, 4'b0001);
      wr(2'd0, 32'hA5, 4'b0001);
      rec_start();
      rd(2'd1, d); checks++; if (d !== 32'h010) begin failures++; $display("FAIL single_status_n got=%h want=010", d); end
      rd(2'd1, d); checks++; if (d !== 32'h005) begin failures++; $display("FAIL single_status_n1 got=%h want=005", d); end
      cycles(45);
      rec = 1'b0;
      exp_q.push_back(1);
      exp_frame(8'hA5, 3);
      repeat (3) exp_q.push_back(1);
      diff = first_diff(0);
      checks++; if (diff != -1) begin failures++;
         $display("FAIL single_wave first bad sample=%0d got=%0d want=%0d", diff,
                  (diff < wave_q.size()) ? wave_q[diff] : -1, exp_q[diff]); end
      rd(2'd1, d); checks++; if (d !== 32'h004) begin failures++; $display("FAIL single_status_end got=%h want=004", d); end
   endtask

   task automatic test_back_to_back();
      int s, diff, hi;
      logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h55};
      wr(2'd2, 32'd1, 4'b0011);
      wr(2'd3, 32'd3, 4'b0001);
      rec_start();
      foreach (bytes[i]) wr(2'd0, {24'b0, bytes[i]}, 4'b0001);
      cycles(70);
      rec = 1'b0;
      foreach (bytes[i]) exp_frame(bytes[i], 1);
      repeat (2) exp_q.push_back(1);
      s = find_start();
      diff = (s < 0) ? 0 : first_diff(s);
      checks++; if (s < 0 || diff != -1) begin failures++; $display("FAIL b2b_wave start=%0d first bad=%0d", s, diff); end
      if (s >= 0 && s + 60 < irq_q.size()) begin
         hi = 0;
         for (int i = s; i < s + 60; i++) hi += irq_q[i];
         checks++; if (hi != 0) begin failures++; $display("FAIL b2b_irq_busy got=%0d high samples want=0", hi); end
         checks++; if (irq_q[s+60] != 1) begin failures++; $display("FAIL b2b_irq_rise got=%0d want=1", irq_q[s+60]); end
      end else begin
         checks++; failures++; $display("FAIL b2b_irq window missing start=%0d", s);
      end
   endtask

   task automatic test_overrun();
      logic [31:0] d;
      logic [7:0] bytes [17];
      int s, diff;
      wr(2'd3, 32'd0, 4'b0001);
      wr(2'd2, 32'd0, 4'b0011);
      foreach (bytes[i]) begin
         bytes[i] = 8'($urandom);
         wr(2'd0, {24'b0, bytes[i]}, 4'b0001);
      end
      rd(2'd1, d); checks++; if (d !== 32'h10A) begin failures++; $display("FAIL ovr_status got=%h want=10a", d); end
      wr(2'd1, 32'h8, 4'b0001);
      rd(2'd1, d); checks++; if (d !== 32'h102) begin failures++; $display("FAIL ovr_clear got=%h want=102", d); end
      rec_start();
      wr(2'd3, 32'd1, 4'b0001);
      cycles(180);
      rec = 1'b0;
      for (int i = 0; i < 16; i++) exp_frame(bytes[i], 0);
      repeat (2) exp_q.push_back(1);
      s = find_start();
      diff = (s < 0) ? 0 : first_diff(s);
      checks++; if (s < 0 || diff != -1) begin failures++; $display("FAIL ovr_wave start=%0d first bad=%0d", s, diff); end
   endtask

   task automatic test_push_at_pop();
      logic [31:0] d;
      logic [7:0] bytes [17];
      int s, diff;
      wr(2'd3, 32'd0, 4'b0001);
      foreach (bytes[i]) bytes[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) wr(2'd0, {24'b0, bytes[i]}, 4'b0001);
      rec_start();
      wr(2'd3, 32'd1, 4'b0001);
      wr(2'd0, {24'b0, bytes[16]}, 4'b0001);
      rd(2'd1, d); checks++; if (d !== 32'h103) begin failures++; $display("FAIL pap_status got=%h want=103", d); end
      cycles(190);
      rec = 1'b0;
      foreach (bytes[i]) exp_frame(bytes[i], 0);
      repeat (2) exp_q.push_back(1);
      s = find_start();
      diff = (s < 0) ? 0 : first_diff(s);
      checks++; if (s < 0 || diff != -1) begin failures++; $display("FAIL pap_wave start=%0d first bad=%0d", s, diff); end
   endtask

   task automatic test_div_change();
      logic [31:0] d;
      logic [7:0] b0, b1;
      int s, diff;
      b0 = 8'($urandom); b1 = 8'($urandom);
      wr(2'd2, 32'd3, 4'b0011);
      wr(2'd3, 32'd1, 4'b0001);
      rec_start();
      wr(2'd0, {24'b0, b0}, 4'b0001);
      wr(2'd0, {24'b0, b1}, 4'b0001);
      cycles(10);
      wr(2'd2, 32'd7, 4'b0011);
      cycles(130);
      rec = 1'b0;
      exp_frame(b0, 3); exp_frame(b1, 7);
      repeat (2) exp_q.push_back(1);
      s = find_start();
      diff = (s < 0) ? 0 : first_diff(s);
      checks++; if (s < 0 || diff != -1) begin failures++; $display("FAIL divchg_wave start=%0d first bad=%0d", s, diff); end
      wr(2'd2, 32'h0100, 4'b0010);
      rd(2'd2, d); checks++; if (d !== 32'h0107) begin failures++; $display("FAIL div_lane1 got=%h want=0107", d); end
      wr(2'd2, 32'hAB12, 4'b0001);
      rd(2'd2, d); checks++; if (d !== 32'h0112) begin failures++; $display("FAIL div_lane0 got=%h want=0112", d); end
      @(negedge clk);
      bus.en = 1'b0; bus.write_en = 1'b0; bus.addr = 32'h8; #1;
      checks++; if (bus.read_data !== 32'h0) begin failures++; $display("FAIL rd_gate_en got=%h want=0", bus.read_data); end
      bus.en = 1'b1; bus.write_en = 1'b1; bus.write_sel = 4'b0; #1;
      checks++; if (bus.read_data !== 32'h0) begin failures++; $display("FAIL rd_gate_we got=%h want=0", bus.read_data); end
      bus.en = 1'b0; bus.write_en = 1'b0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         int div, n, s, diff;
         logic [7:0] b;
         div = $urandom_range(0, 2);
         n = $urandom_range(1, 5);
         wr(2'd2, div, 4'b0011);
         wr(2'd3, 32'd3, 4'b0001);
         rec_start();
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_frame(b, div);
            wr(2'd0, {24'b0, b}, 4'b0001);
         end
         cycles(n * 10 * (div + 1) + 20);
         rec = 1'b0;
         s = find_start();
         diff = (s < 0) ? 0 : first_diff(s);
         checks++; if (s < 0 || diff != -1) begin failures++; $display("FAIL rand_wave it=%0d div=%0d n=%0d first bad=%0d", it, div, n, diff); end
         if (s >= 1 && s + exp_q.size() < irq_q.size()) begin
            checks++; if (irq_q[s + exp_q.size()] != 1 || irq_q[s + exp_q.size() - 1] != 0) begin failures++;
               $display("FAIL rand_irq it=%0d got=%0d%0d want=01", it, irq_q[s + exp_q.size() - 1], irq_q[s + exp_q.size()]); end
         end else begin
            checks++; failures++; $display("FAIL rand_irq it=%0d window missing", it);
         end
      end
   endtask

   task automatic test_midframe_reset();
      logic [31:0] d;
      int hi;
      wr(2'd2, 32'd3, 4'b0011);
      wr(2'd3, 32'd1, 4'b0001);
      wr(2'd0, 32'h00, 4'b0001);
      cycles(8);
      checks++; if (txd !== 1'b0) begin failures++; $display("FAIL mid_txd_low got=%b want=0", txd); end
      #2 rst = 1'b0;
      #1;
      checks++; if (txd !== 1'b1) begin failures++; $display("FAIL mid_rst_txd got=%b want=1", txd); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_rst_irq got=%b want=0", irq); end
      rd(2'd1, d); checks++; if (d !== 32'h004) begin failures++; $display("FAIL mid_rst_status got=%h want=004", d); end
      rd(2'd2, d); checks++; if (d !== 32'd433) begin failures++; $display("FAIL mid_rst_div got=%0d want=433", d); end
      rd(2'd3, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL mid_rst_ctrl got=%h want=0", d); end
      @(negedge clk) rst = 1'b1;
      rec_start();
      cycles(50);
      rec = 1'b0;
      hi = 0;
      foreach (wave_q[i]) hi += wave_q[i];
      checks++; if (hi != wave_q.size() || hi == 0) begin failures++; $display("FAIL mid_no_resume high=%0d of %0d", hi, wave_q.size()); end
   endtask

   initial begin
      bus.en = 1'b0; bus.write_en = 1'b0; bus.write_sel = 4'b0;
      bus.addr = '0; bus.write_data = '0;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overrun();
      test_push_at_pop();
      test_div_change();
      test_random();
      test_midframe_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
